// File: rtl/diff_pdm_pkg.sv
// Shared types and helpers for the differential PDM driver.
// Build option DIFF_PDM_DEADTIME_EN enables break-before-make on bit changes.
package diff_pdm_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_FRAME_LEN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PARK = 2'd2
    } state_t;

    // Signed two's complement to offset binary: flip bit w-1.
    function automatic logic [63:0] offset_bin(input logic [63:0] v,
                                                input int w);
        return v ^ (64'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/pdm_accum.sv
// First-order sigma-delta accumulator; the carry of acc+u is the PDM bit.
// clear makes the current step start from zero (fresh frame entry).
import diff_pdm_pkg::*;

module pdm_accum #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic [WIDTH-1:0] u,
    output logic             pdm_bit
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;

    assign base    = clear ? '0 : acc;
    assign sum     = {1'b0, base} + {1'b0, u};
    assign pdm_bit = sum[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (step) begin
            acc <= sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/diff_pdm_driver.sv
// Complementary PDM pair driver for comparator stimulus and self-test.
// Define DIFF_PDM_DEADTIME_EN for a 0/0 dead cycle whenever the bit flips.
import diff_pdm_pkg::*;

module diff_pdm_driver #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] code,
    input  logic             code_valid,
    output logic             code_ready,
    output logic             vip,
    output logic             vin,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] code_q;
    logic [WIDTH-1:0] u;
    logic             last;
    logic             accept;
    logic             step;
    logic             clear;
    logic             pdm_bit;
    logic             dead;

    assign last       = (state == RUN) && (cnt == '0);
    assign code_ready = en && ((state == IDLE) || last);
    assign frame_done = last && en;
    assign busy       = (state != IDLE);
    assign accept     = code_valid && code_ready;
    assign clear      = (state == IDLE);
    assign step       = accept || ((state == RUN) && en && (cnt != '0));
    assign u          = WIDTH'(offset_bin(64'(accept ? code : code_q), WIDTH));

    pdm_accum #(.WIDTH(WIDTH)) u_accum (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .step    (step),
        .u       (u),
        .pdm_bit (pdm_bit)
    );

`ifdef DIFF_PDM_DEADTIME_EN
    logic prev;

    // Only a change between two RUN cycles is dead; frame entry never is.
    assign dead = (state == RUN) && (pdm_bit != prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else if (step) begin
            prev <= pdm_bit;
        end
    end
`else
    assign dead = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            code_q <= '0;
            vip    <= 1'b0;
            vin    <= 1'b0;
        end else begin
            vip <= 1'b0;
            vin <= 1'b0;
            if (step) begin
                vip <= pdm_bit & ~dead;
                vin <= ~pdm_bit & ~dead;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= RUN;
                        cnt    <= LAST;
                        code_q <= code;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= PARK;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (accept) begin
                        cnt    <= LAST;
                        code_q <= code;
                    end else begin
                        state <= PARK;
                    end
                end
                PARK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_diff_pdm_driver.sv
// Scoreboard bench for diff_pdm_driver (WIDTH=8, FRAME_LEN=16).
// Expected per-cycle vip/vin/frame_done come from a reference accumulator.
module tb_diff_pdm_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] code = 8'h00;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic       vip;
    logic       vin;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic vip;
        logic vin;
        logic fd;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] m_acc = 8'h00;
    logic       m_prev = 1'b0;

    diff_pdm_driver #(.WIDTH(8), .FRAME_LEN(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .vip        (vip),
        .vin        (vin),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    // Reference model: one frame of expected outputs from the given code.
    task automatic push_frame(input logic [7:0] c, input bit fresh);
        logic [8:0] s;
        logic       b;
        logic       dead;
        if (fresh) m_acc = 8'h00;
        for (int k = 0; k < 16; k++) begin
            s = {1'b0, m_acc} + {1'b0, c ^ 8'h80};
            m_acc = s[7:0];
            b = s[8];
            dead = 1'b0;
`ifdef DIFF_PDM_DEADTIME_EN
            dead = !(fresh && k == 0) && (b != m_prev);
`endif
            m_prev = b;
            sb.push_back(exp_t'{b & ~dead, ~b & ~dead, k == 15});
        end
    endtask

    task automatic accept_code(input logic [7:0] c);
        @(negedge clk);
        code = c;
        code_valid = 1'b1;
        @(posedge clk);
        #1 code_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({vip, vin, code_ready, busy, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset: got vip,vin,rdy,busy,fd=%b want 00000",
                     {vip, vin, code_ready, busy, frame_done});
        end
        en = 1'b1;
        #1;
        checks++;
        if (code_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b want 1", code_ready);
        end
    endtask

    task automatic test_mid_code;
        int ones = 0;
        int want_ones;
        accept_code(8'h00);
        push_frame(8'h00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            ones += int'(vip);
            checks++;
            if ({vip, vin, frame_done, busy, code_ready} !==
                {e.vip, e.vin, e.fd, 1'b1, i == 15}) begin
                errors++;
                $display("FAIL zero_c%0d: got vip,vin,fd,busy,rdy=%b want %b",
                         i, {vip, vin, frame_done, busy, code_ready},
                         {e.vip, e.vin, e.fd, 1'b1, i == 15});
            end
        end
`ifdef DIFF_PDM_DEADTIME_EN
        want_ones = 0;
`else
        want_ones = 8;
`endif
        checks++;
        if (ones != want_ones) begin
            errors++;
            $display("FAIL zero_ones: got %0d want %0d", ones, want_ones);
        end
        @(negedge clk);
        checks++;
        if ({vip, vin, busy, code_ready, frame_done} !== 5'b00100) begin
            errors++;
            $display("FAIL zero_park: got %b want 00100",
                     {vip, vin, busy, code_ready, frame_done});
        end
        @(negedge clk);
        checks++;
        if ({busy, code_ready} !== 2'b01) begin
            errors++;
            $display("FAIL zero_idle: got busy,rdy=%b want 01",
                     {busy, code_ready});
        end
    endtask

    task automatic test_extremes;
        logic [7:0] codes [2];
        codes[0] = 8'h80;
        codes[1] = 8'h7F;
        for (int c = 0; c < 2; c++) begin
            accept_code(codes[c]);
            push_frame(codes[c], 1'b1);
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                e = sb.pop_front();
                checks++;
                if ({vip, vin, frame_done} !== {e.vip, e.vin, e.fd}) begin
                    errors++;
                    $display("FAIL ext_%h_c%0d: got vip,vin,fd=%b want %b",
                             codes[c], i, {vip, vin, frame_done},
                             {e.vip, e.vin, e.fd});
                end
            end
            if (c == 0) begin
                checks++;
                if ({vip, vin} !== 2'b01) begin
                    errors++;
                    $display("FAIL ext_min_last: got %b want 01", {vip, vin});
                end
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        accept_code(8'h40);
        code = 8'hC0;
        code_valid = 1'b1;
        push_frame(8'h40, 1'b1);
        push_frame(8'hC0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({vip, vin, frame_done, busy, code_ready} !==
                {e.vip, e.vin, e.fd, 1'b1, (i % 16) == 15}) begin
                errors++;
                $display("FAIL b2b_c%0d: got vip,vin,fd,busy,rdy=%b want %b",
                         i, {vip, vin, frame_done, busy, code_ready},
                         {e.vip, e.vin, e.fd, 1'b1, (i % 16) == 15});
            end
            if (i == 15) begin
                @(posedge clk);
                #1 code_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({vip, vin, busy} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_park: got %b want 001", {vip, vin, busy});
        end
        @(negedge clk);
    endtask

    task automatic test_en_drop;
        accept_code(8'h00);
        push_frame(8'h00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({vip, vin, frame_done} !== {e.vip, e.vin, e.fd}) begin
                errors++;
                $display("FAIL endrop_c%0d: got %b want %b", i,
                         {vip, vin, frame_done}, {e.vip, e.vin, e.fd});
            end
        end
        en = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({vip, vin, busy, frame_done, code_ready} !== 5'b00100) begin
            errors++;
            $display("FAIL endrop_park: got %b want 00100",
                     {vip, vin, busy, frame_done, code_ready});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({busy, code_ready, frame_done} !== 3'b000) begin
                errors++;
                $display("FAIL endrop_idle: got busy,rdy,fd=%b want 000",
                         {busy, code_ready, frame_done});
            end
        end
        en = 1'b1;
        #1;
        checks++;
        if (code_ready !== 1'b1) begin
            errors++;
            $display("FAIL endrop_return: got %b want 1", code_ready);
        end
    endtask

    task automatic test_rst_mid;
        accept_code(8'h33);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({vip, vin, busy, frame_done, code_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL rst_mid: got vip,vin,busy,fd,rdy=%b want 00001",
                     {vip, vin, busy, frame_done, code_ready});
        end
        accept_code(8'hA5);
        push_frame(8'hA5, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({vip, vin, frame_done} !== {e.vip, e.vin, e.fd}) begin
                errors++;
                $display("FAIL post_rst_c%0d: got %b want %b", i,
                         {vip, vin, frame_done}, {e.vip, e.vin, e.fd});
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mid_code();
        test_extremes();
        test_back_to_back();
        test_en_drop();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
